// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode/func constants, ALUOp codes and controller states
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_J        = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  // SPECIAL2 function codes
  localparam logic [5:0] FN_CL1 = 6'b100001;
  localparam logic [5:0] FN_CLZ = 6'b100000;
  localparam logic [5:0] FN_ROT = 6'b000110;
  localparam logic [5:0] FN_MUL = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_ROT = 4'b1010;
  localparam logic [3:0] ALU_CL1 = 4'b1011;
  localparam logic [3:0] ALU_CLZ = 4'b1100;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    WB_R,
    EXEC_I,
    WB_I,
    MEM_ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    MUL_START,
    MUL_WAIT,
    BRANCH,
    JUMP
  } ctrlState;

  function automatic logic isMulOp(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_SPECIAL2) && (fn == FN_MUL);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational R-type/SPECIAL2 decode to ALUOp and shifter selects
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [3:0] aluOp,
  output logic       shlSel,
  output logic       shrSel,
  output logic       valid
);

  // valid only covers the register-format encodings; I-type ops are dispatched by the top
  always_comb begin
    aluOp  = ALU_ADD;
    shlSel = 1'b0;
    shrSel = 1'b0;
    valid  = 1'b0;
    case (op)
      OP_RTYPE: begin
        valid = 1'b1;
        case (func)
          FN_ADD: aluOp = ALU_ADD;
          FN_SUB: aluOp = ALU_SUB;
          FN_AND: aluOp = ALU_AND;
          FN_OR:  aluOp = ALU_OR;
          FN_SLT: aluOp = ALU_SLT;
          FN_SLL: begin
            aluOp  = ALU_SLL;
            shlSel = 1'b1;
          end
          FN_SRL: begin
            aluOp  = ALU_SRL;
            shrSel = 1'b1;
          end
          default: valid = 1'b0;
        endcase
      end
      OP_SPECIAL2: begin
        valid = 1'b1;
        case (func)
          FN_CL1:  aluOp = ALU_CL1;
          FN_CLZ:  aluOp = ALU_CLZ;
          FN_ROT:  aluOp = ALU_ROT;
          FN_MUL:  aluOp = ALU_MUL;
          default: valid = 1'b0;
        endcase
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS control FSM with memory/multiplier stalls
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int MUL_TIMEOUT = 64
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [5:0] Op,
  input  logic [5:0] func,
  input  logic       Zero,
  input  logic       mem_ready,
  input  logic       mul_done,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       shl_sel,
  output logic       shr_sel,
  output logic       mul_start,
  output logic       illegal
);

  localparam int CntW = (MUL_TIMEOUT > 2) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_TIMEOUT - 1);

  ctrlState        state;
  ctrlState        nextState;
  logic [CntW-1:0] mulCount;
  logic            mulTimeout;
  logic [3:0]      decAluOp;
  logic            decShl;
  logic            decShr;
  logic            decValid;
  logic            unusedZero;

  alu_decoder uDec (
    .op     (Op),
    .func   (func),
    .aluOp  (decAluOp),
    .shlSel (decShl),
    .shrSel (decShr),
    .valid  (decValid)
  );

  // The datapath ANDs Zero with PCWriteCond itself
  assign unusedZero = Zero;
  assign mulTimeout = (mulCount == CntLast);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= FETCH;
      mulCount <= '0;
    end else begin
      state <= nextState;
      if (state == MUL_START) begin
        mulCount <= '0;
      end else if (state == MUL_WAIT) begin
        mulCount <= mulCount + 1'b1;
      end
    end
  end

  always_comb begin
    nextState   = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = ALU_ADD;
    shl_sel     = 1'b0;
    shr_sel     = 1'b0;
    mul_start   = 1'b0;
    illegal     = 1'b0;
    // While reset is held, present the idle FETCH decode so no write strobe escapes
    if (Rst) begin
      nextState = FETCH;
      MemRead   = 1'b1;
      ALUSrcB   = 2'b01;
    end else begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          if (mem_ready) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            nextState = DECODE;
          end
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          case (Op)
            OP_RTYPE, OP_SPECIAL2: begin
              if (!decValid) begin
                illegal   = 1'b1;
                nextState = FETCH;
              end else if (isMulOp(Op, func)) begin
                nextState = MUL_START;
              end else begin
                nextState = EXEC_R;
              end
            end
            OP_ADDI, OP_ORI: nextState = EXEC_I;
            OP_LW, OP_SW:    nextState = MEM_ADDR;
            OP_BEQ:          nextState = BRANCH;
            OP_J:            nextState = JUMP;
            default: begin
              illegal   = 1'b1;
              nextState = FETCH;
            end
          endcase
        end
        EXEC_R: begin
          ALUSrcA   = 1'b1;
          ALUOp     = decAluOp;
          shl_sel   = decShl;
          shr_sel   = decShr;
          nextState = WB_R;
        end
        WB_R: begin
          RegDst    = 1'b1;
          RegWrite  = 1'b1;
          ALUOp     = decAluOp;
          shl_sel   = decShl;
          shr_sel   = decShr;
          nextState = FETCH;
        end
        EXEC_I, WB_I: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ALUOp     = (Op == OP_ORI) ? ALU_OR : ALU_ADD;
          RegWrite  = (state == WB_I);
          nextState = (state == EXEC_I) ? WB_I : FETCH;
        end
        MEM_ADDR: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          nextState = (Op == OP_LW) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) nextState = WB_MEM;
        end
        WB_MEM: begin
          MemtoReg  = 1'b1;
          RegWrite  = 1'b1;
          nextState = FETCH;
        end
        MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) nextState = FETCH;
        end
        MUL_START: begin
          mul_start = 1'b1;
          ALUOp     = ALU_MUL;
          ALUSrcA   = 1'b1;
          nextState = MUL_WAIT;
        end
        MUL_WAIT: begin
          ALUOp   = ALU_MUL;
          ALUSrcA = 1'b1;
          // A result arriving on the last allowed cycle still counts
          if (mul_done) begin
            nextState = WB_R;
          end else if (mulTimeout) begin
            illegal   = 1'b1;
            nextState = FETCH;
          end
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          nextState   = FETCH;
        end
        JUMP: begin
          PCWrite   = 1'b1;
          PCSource  = 2'b10;
          nextState = FETCH;
        end
        default: nextState = FETCH;
      endcase
    end
  end

endmodule
